// File: rtl/mult_seq.sv
// Sequential shift-add unsigned multiplier: one product bit per cycle.
// The datapath is busy for WIDTH+1 cycles, and the pipeline stalls while it is busy.
module mult_seq #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             n_reset,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             mult_flag,
   output logic             stall,
   output logic             done,
   output logic             reg_we,
   output logic [WIDTH-1:0] result_hi,
   output logic [WIDTH-1:0] result_lo
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [WIDTH-1:0]   mcand;
   logic [2*WIDTH-1:0] prod;

   // The add is WIDTH+1 bits wide so its carry becomes the new top bit after the shift.
   function automatic logic [2*WIDTH-1:0] shift_add(input logic [2*WIDTH-1:0] p,
                                                    input logic [WIDTH-1:0]   m);
      logic [WIDTH:0] sum;
      sum = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
      return {sum, p[WIDTH-1:1]};
   endfunction

   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         state <= IDLE;
         cnt   <= '0;
         mcand <= '0;
         prod  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  mcand <= op_a;
                  prod  <= {{WIDTH{1'b0}}, op_b};
                  cnt   <= '0;
                  state <= RUN;
               end
            end
            RUN: begin
               prod <= shift_add(prod, mcand);
               cnt  <= cnt + CNT_W'(1);
               if (cnt == LAST_STEP) state <= DONE;
            end
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign mult_flag = (state != IDLE);
   assign stall     = mult_flag;
   assign done      = (state == DONE);
   assign reg_we    = done;
   assign result_hi = prod[2*WIDTH-1:WIDTH];
   assign result_lo = prod[WIDTH-1:0];

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq (WIDTH=8): directed vector table, multi-cycle corner sequences,
// and random operands checked against plain a*b arithmetic.
module tb_mult_seq;

   logic       clk;
   logic       n_reset;
   logic       start;
   logic [7:0] op_a, op_b;
   logic       mult_flag, stall, done, reg_we;
   logic [7:0] result_hi, result_lo;

   int n_checks = 0;
   int n_pass   = 0;

   mult_seq #(.WIDTH(8)) dut (
      .clk       (clk),
      .n_reset   (n_reset),
      .start     (start),
      .op_a      (op_a),
      .op_b      (op_b),
      .mult_flag (mult_flag),
      .stall     (stall),
      .done      (done),
      .reg_we    (reg_we),
      .result_hi (result_hi),
      .result_lo (result_lo)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] prod;
   } vec_t;

   vec_t tbl [6];

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // One complete multiply; returns result, latency from start edge to done, busy cycles.
   task automatic do_mult(input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] res, output int lat, output int busy,
                          output int side_err);
      res = '0; busy = 0; side_err = 0;
      @(negedge clk);
      op_a = a; op_b = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      while (lat <= 40) begin
         if (stall !== mult_flag || reg_we !== done) side_err++;
         if (mult_flag) busy++;
         if (done) begin
            res = {result_hi, result_lo};
            break;
         end
         @(negedge clk);
         lat++;
      end
   endtask

   logic [15:0] res;
   int lat, busy, side_err;
   int ndone, dcyc, d1, d2, gap, bad;
   logic [15:0] got;
   logic [7:0]  ra, rb;

   initial begin
      tbl[0] = '{8'hFF, 8'hFF, 16'hFE01};
      tbl[1] = '{8'h80, 8'h02, 16'h0100};
      tbl[2] = '{8'h00, 8'hA5, 16'h0000};
      tbl[3] = '{8'h12, 8'h34, 16'h03A8};
      tbl[4] = '{8'h0F, 8'h0F, 16'h00E1};
      tbl[5] = '{8'h01, 8'hFF, 16'h00FF};

      n_reset = 1'b0; start = 1'b0; op_a = '0; op_b = '0;
      repeat (3) @(negedge clk);
      check("reset_outputs", 64'({mult_flag, stall, done, reg_we, result_hi, result_lo}), 64'd0);
      n_reset = 1'b1;
      @(negedge clk);

      // Directed vector table
      for (int i = 0; i < 6; i++) begin
         do_mult(tbl[i].a, tbl[i].b, res, lat, busy, side_err);
         check($sformatf("vec%0d_result", i), 64'(res), 64'(tbl[i].prod));
         check($sformatf("vec%0d_latency", i), 64'(lat), 64'd9);
         check($sformatf("vec%0d_busy", i), 64'(busy), 64'd9);
         check($sformatf("vec%0d_stall_we", i), 64'(side_err), 64'd0);
         @(negedge clk);
         check($sformatf("vec%0d_idle_hold", i),
               64'({mult_flag, done, result_hi, result_lo}), 64'({2'b00, tbl[i].prod}));
      end

      // start re-pulsed mid-run, operands changed after capture
      @(negedge clk);
      op_a = 8'hC3; op_b = 8'h5A; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      ndone = 0; dcyc = 0; got = '0;
      for (int c = 1; c <= 20; c++) begin
         if (c == 2) begin op_a = 8'($urandom); op_b = 8'($urandom); end
         if (done) begin ndone++; dcyc = c; got = {result_hi, result_lo}; end
         start = (c == 3);
         @(negedge clk);
      end
      start = 1'b0;
      check("repulse_done_count", 64'(ndone), 64'd1);
      check("repulse_done_cycle", 64'(dcyc), 64'd9);
      check("repulse_result", 64'(got), 64'h448E);

      // start held high for 25 cycles
      @(negedge clk);
      op_a = 8'h0F; op_b = 8'h11; start = 1'b1;
      ndone = 0; d1 = 0; d2 = 0; gap = 0; bad = 0;
      for (int c = 1; c <= 25; c++) begin
         @(negedge clk);
         if (done) begin
            ndone++;
            if (ndone == 1) d1 = c; else if (ndone == 2) d2 = c;
            if ({result_hi, result_lo} !== 16'h00FF) bad++;
         end
         if (!mult_flag) gap++;
      end
      start = 1'b0;
      check("held_done_count", 64'(ndone), 64'd2);
      check("held_first_done", 64'(d1), 64'd9);
      check("held_second_done", 64'(d2), 64'd19);
      check("held_idle_gaps", 64'(gap), 64'd2);
      check("held_results", 64'(bad), 64'd0);
      ndone = 0;
      for (int c = 0; c < 20 && mult_flag; c++) begin
         if (done) begin ndone++; got = {result_hi, result_lo}; end
         @(negedge clk);
      end
      check("held_third_drain", 64'({ndone[1:0], mult_flag, got}), 64'({2'd1, 1'b0, 16'h00FF}));

      // Reset in the middle of a run
      @(negedge clk);
      op_a = 8'h37; op_b = 8'h29; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      n_reset = 1'b0;
      #1;
      check("abort_outputs_zero",
            64'({mult_flag, stall, done, reg_we, result_hi, result_lo}), 64'd0);
      @(negedge clk);
      n_reset = 1'b1;
      bad = 0;
      for (int c = 0; c < 15; c++) begin
         if (done || mult_flag) bad++;
         @(negedge clk);
      end
      check("abort_no_done", 64'(bad), 64'd0);
      do_mult(8'h37, 8'h29, res, lat, busy, side_err);
      check("after_abort_result", 64'(res), 64'h08CF);
      check("after_abort_latency", 64'(lat), 64'd9);

      // Random operands against arithmetic reference
      for (int i = 0; i < 40; i++) begin
         ra = 8'($urandom);
         rb = 8'($urandom_range(0, 255));
         do_mult(ra, rb, res, lat, busy, side_err);
         check($sformatf("rand%0d_%02h_x_%02h", i, ra, rb), 64'(res), 64'(16'(ra) * 16'(rb)));
         check($sformatf("rand%0d_timing", i), 64'({lat[7:0], busy[7:0], side_err[7:0]}),
               64'({8'd9, 8'd9, 8'd0}));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mult_seq.md
MULT_SEQ -- requirements
Module: mult_seq

Interface
REQ-001 The block SHALL have one clock and reset SHALL be asynchronous and active-low.
REQ-002 Parameter WIDTH, default 8: operand width in bits; legal values 4 to 16.
REQ-003 Port clk, input, 1: rising-edge clock.
REQ-004 Port n_reset, input, 1: asynchronous active-low reset.
REQ-005 Port start, input, 1: request a multiply; sampled only in IDLE.
REQ-006 Port op_a, input, WIDTH: multiplicand, unsigned; captured with start.
REQ-007 Port op_b, input, WIDTH: multiplier, unsigned; captured with start.
REQ-008 Port mult_flag, output, 1: high while a multiply occupies the datapath; drives the register-address select stage.
REQ-009 Port stall, output, 1: freezes PC/fetch; equals mult_flag.
REQ-010 Port done, output, 1: one-cycle pulse, result valid.
REQ-011 Port reg_we, output, 1: write-enable for result into the destination register; equals done.
REQ-012 Port result_hi, output, WIDTH: upper half of the product.
REQ-013 Port result_lo, output, WIDTH: lower half of the product.

Function
REQ-014 The FSM SHALL have three states: IDLE, RUN, DONE.
REQ-015 In IDLE with start=1 at a clock edge, the block SHALL capture op_a into the multiplicand register and op_b into prod[WIDTH-1:0], clear prod[2*WIDTH-1:WIDTH], clear the iteration counter, and enter RUN.
REQ-016 In IDLE with start=0, the block SHALL remain in IDLE with all registers held.
REQ-017 Each RUN cycle SHALL perform one shift-add step.
- If prod[0]=1: prod = ({carry, prod[2W-1:W] + mcand}, prod[W-1:0]) >> 1.
- Otherwise: prod = prod >> 1.
- The add SHALL be WIDTH+1 bits so the carry is never lost.
REQ-018 The iteration counter SHALL be $clog2(WIDTH) bits; it SHALL increment each RUN cycle and SHALL NOT wrap before the exit.
REQ-019 At the RUN edge where counter = WIDTH-1, the block SHALL enter DONE; RUN therefore lasts exactly WIDTH cycles.
REQ-020 DONE SHALL last exactly one cycle with done=1 and reg_we=1, then return to IDLE unconditionally.
REQ-021 mult_flag and stall SHALL be 1 in RUN and DONE and 0 in IDLE, decoded from state with no extra register delay.
REQ-022 Latency SHALL be fixed: start sampled at edge k gives done=1 during cycle k+WIDTH+1, and mult_flag high for WIDTH+1 cycles.
REQ-023 result_hi/result_lo SHALL be driven from prod[2W-1:W] and prod[W-1:0]; they are valid only when done=1, and in IDLE they SHALL hold the last product until the next start.
REQ-024 start asserted in RUN or DONE SHALL be ignored, with no queuing; start held high continuously SHALL launch a new multiply at the first edge in IDLE, one cycle after DONE.
REQ-025 Changes on op_a/op_b after capture SHALL NOT affect the in-flight product.
REQ-026 The product SHALL be exact for all operand pairs: result = op_a*op_b modulo 2^(2*WIDTH), with no overflow possible.

Reset
REQ-027 While n_reset=0, the block SHALL force state=IDLE, counter=0, prod=0, mcand=0, mult_flag=0, stall=0, done=0, reg_we=0, result_hi=0, result_lo=0, independent of clk.
REQ-028 Reset asserted during RUN or DONE SHALL abort the multiply with no done pulse, and the first edge after release SHALL see IDLE.

Verification
REQ-029 Every bench run SHALL cover the following directed scenarios with WIDTH=8:
- Operands 0xFF, 0xFF with a start pulse: mult_flag high for 9 cycles; done one cycle at k+9; result_hi=0xFE, result_lo=0x01.
- Operands 0x80, 0x02: result_hi=0x01, result_lo=0x00.
- Operands 0x00, 0xA5: result 0x0000 with the same fixed latency.
- start re-pulsed during RUN at cycle k+3: ignored, exactly one done, correct result.
- start held high for 25 cycles: done at k+9 and k+19; IDLE gap of one cycle between busy windows.
- n_reset pulsed low at cycle k+4: all outputs 0 immediately, no done; a new start afterwards completes with the correct product.
